spi_master: RTL and testbench

Byte-oriented SPI master. It is the initiator counterpart of the CPLD's SPI slave port (spi_cs/spi_sck/spi_si/spi_so) and is used to drive that port from a bridge or self-test harness and to configure external SPI peripherals. It operates in mode 0, MSB first, with an active-low chip select. Chip select is held across multi-byte bursts and framed by a tx_last flag.

---
 rtl/spi_master.sv | 155 +++++++++++++++
 tb/tb_spi_master.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Byte-oriented SPI master: mode 0, MSB first, active-low chip select.
// Chip select stays low across a burst; the byte flagged tx_last closes the frame.
module spi_master #(
    parameter int CLK_DIV = 4,
    parameter int DIV_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       spi_cs,
    output logic       spi_sck,
    output logic       spi_si,
    input  logic       spi_so
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        WAIT,
        TRAIL,
        GAP
    } state_t;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div, div_nxt, div_step;
    logic [2:0]       bit_cnt, bit_cnt_nxt;
    logic [6:0]       tx_sh, tx_sh_nxt;
    logic [7:0]       rx_sh, rx_sh_nxt;
    logic [7:0]       rx_data_nxt;
    logic             last, last_nxt;
    logic             cs_nxt, sck_nxt, si_nxt, rx_valid_nxt;
    logic             tick, accept;

    assign tick     = (div == DIV_MAX);
    assign div_step = tick ? '0 : div + DIV_W'(1);
    assign tx_ready = (state == IDLE) || (state == WAIT);
    assign accept   = tx_valid && tx_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div      <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            last     <= 1'b0;
            spi_cs   <= 1'b1;
            spi_sck  <= 1'b0;
            spi_si   <= 1'b0;
        end else begin
            state    <= state_nxt;
            div      <= div_nxt;
            bit_cnt  <= bit_cnt_nxt;
            tx_sh    <= tx_sh_nxt;
            rx_sh    <= rx_sh_nxt;
            rx_data  <= rx_data_nxt;
            rx_valid <= rx_valid_nxt;
            last     <= last_nxt;
            spi_cs   <= cs_nxt;
            spi_sck  <= sck_nxt;
            spi_si   <= si_nxt;
        end
    end

    // Every SPI pin is computed here and registered above, so the pins never glitch.
    always_comb begin
        state_nxt    = state;
        div_nxt      = div;
        bit_cnt_nxt  = bit_cnt;
        tx_sh_nxt    = tx_sh;
        rx_sh_nxt    = rx_sh;
        rx_data_nxt  = rx_data;
        rx_valid_nxt = 1'b0;
        last_nxt     = last;
        cs_nxt       = spi_cs;
        sck_nxt      = spi_sck;
        si_nxt       = spi_si;

        case (state)
            IDLE, WAIT: begin
                if (accept) begin
                    tx_sh_nxt   = tx_data[6:0];
                    last_nxt    = tx_last;
                    cs_nxt      = 1'b0;
                    si_nxt      = tx_data[7];
                    div_nxt     = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = LEAD;
                end
            end

            LEAD: begin
                div_nxt = div_step;
                if (tick) begin
                    state_nxt = SHIFT;
                end
            end

            // Rising SCK samples spi_so; falling SCK advances spi_si, except after bit 0.
            SHIFT: begin
                div_nxt = div_step;
                if (tick) begin
                    if (!spi_sck) begin
                        sck_nxt   = 1'b1;
                        rx_sh_nxt = {rx_sh[6:0], spi_so};
                    end else begin
                        sck_nxt = 1'b0;
                        if (bit_cnt == 3'd7) begin
                            rx_data_nxt  = rx_sh;
                            rx_valid_nxt = 1'b1;
                            state_nxt    = last ? TRAIL : WAIT;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 3'd1;
                            si_nxt      = tx_sh[6];
                            tx_sh_nxt   = {tx_sh[5:0], 1'b0};
                        end
                    end
                end
            end

            TRAIL: begin
                div_nxt = div_step;
                if (tick) begin
                    cs_nxt    = 1'b1;
                    si_nxt    = 1'b0;
                    state_nxt = GAP;
                end
            end

            GAP: begin
                div_nxt = div_step;
                if (tick) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master.sv
// Randomised self-checking bench for spi_master: a mode-0 slave model plus
// timing expectations derived from the frame rules with plain arithmetic.
module tb_spi_master;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int tests = 0;
    int fails = 0;

    // DUT with CLK_DIV = 4
    logic [7:0] tx_data;
    logic       tx_valid, tx_last;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, busy, spi_cs, spi_sck, spi_si;
    logic       loop_en;
    logic       slave_so;
    wire        spi_so = loop_en ? spi_si : slave_so;

    spi_master #(.CLK_DIV(D), .DIV_W(8)) dut (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_si(spi_si), .spi_so(spi_so)
    );

    // DUT with CLK_DIV = 1, slave output tied low
    logic [7:0] tx_data1;
    logic       tx_valid1, tx_last1;
    logic       tx_ready1;
    logic [7:0] rx_data1;
    logic       rx_valid1, busy1, cs1, sck1, si1;
    logic       so1 = 1'b0;

    spi_master #(.CLK_DIV(1), .DIV_W(8)) dut1 (
        .clk(clk), .rst(rst),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_last(tx_last1), .tx_ready(tx_ready1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1),
        .spi_cs(cs1), .spi_sck(sck1), .spi_si(si1), .spi_so(so1)
    );

    // Mode-0 slave: MSB ready when CS falls, next bit shifted out on each SCK fall
    logic [7:0] miso_q[$];
    logic [7:0] so_byte = 8'h00;
    int         so_bits = 0;

    always @(negedge spi_cs) begin
        so_bits = 0;
        so_byte = 8'h00;
        if (miso_q.size() > 0) so_byte = miso_q.pop_front();
        slave_so = so_byte[7];
    end

    always @(negedge spi_sck) begin
        if (!spi_cs) begin
            so_bits = so_bits + 1;
            if (so_bits == 8) begin
                so_bits = 0;
                so_byte = 8'h00;
                if (miso_q.size() > 0) so_byte = miso_q.pop_front();
            end else begin
                so_byte = {so_byte[6:0], 1'b0};
            end
            slave_so = so_byte[7];
        end
    end

    // Event log of the CLK_DIV=4 pins, sampled on the falling clk edge
    int         rise_t[$], fall_t[$], csf_t[$], csr_t[$], rxv_t[$], acc_t[$], busyf_t[$];
    logic [7:0] rxd_q[$], mosi_q[$];
    int         bad_high, bad_low, si_glitch, mosi_bits, last_rise, last_fall;
    logic [7:0] mosi_sh;
    logic       p_cs = 1'b1, p_sck = 1'b0, p_si = 1'b0, p_busy = 1'b0;

    always @(negedge clk) begin
        if (p_cs && !spi_cs) csf_t.push_back(cyc);
        if (!p_cs && spi_cs) begin
            csr_t.push_back(cyc);
            mosi_bits = 0;
        end
        if (!p_sck && spi_sck) begin
            rise_t.push_back(cyc);
            if (spi_si !== p_si) si_glitch = si_glitch + 1;
            if (mosi_bits != 0 && cyc - last_fall != D) bad_low = bad_low + 1;
            last_rise = cyc;
            mosi_sh   = {mosi_sh[6:0], spi_si};
            mosi_bits = mosi_bits + 1;
            if (mosi_bits == 8) begin
                mosi_q.push_back(mosi_sh);
                mosi_bits = 0;
            end
        end
        if (p_sck && !spi_sck) begin
            fall_t.push_back(cyc);
            if (cyc - last_rise != D) bad_high = bad_high + 1;
            last_fall = cyc;
        end
        if (p_busy && !busy) busyf_t.push_back(cyc);
        if (rx_valid) begin
            rxv_t.push_back(cyc);
            rxd_q.push_back(rx_data);
        end
        if (tx_valid && tx_ready) acc_t.push_back(cyc);
        p_cs   = spi_cs;
        p_sck  = spi_sck;
        p_si   = spi_si;
        p_busy = busy;
    end

    function automatic int qi(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1000000;
    endfunction

    function automatic logic [7:0] qb(input logic [7:0] q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return 8'bx;
    endfunction

    task automatic clear_mon();
        rise_t.delete(); fall_t.delete(); csf_t.delete(); csr_t.delete();
        rxv_t.delete(); acc_t.delete(); busyf_t.delete();
        rxd_q.delete(); mosi_q.delete(); miso_q.delete();
        bad_high = 0; bad_low = 0; si_glitch = 0; mosi_bits = 0;
        last_rise = 0; last_fall = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        @(posedge clk); #1;
        tx_data  = d;
        tx_last  = l;
        tx_valid = 1'b1;
        @(negedge clk);
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            tests++; fails++;
            $display("[TB] FAIL send_timeout: tx_ready=%0b after %0d cycles, required 1", tx_ready, n);
        end
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            tests++; fails++;
            $display("[TB] FAIL idle_timeout: busy=%0b after %0d cycles, required 0", busy, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++; if (spi_cs !== 1'b1) begin fails++; $display("[TB] FAIL reset_cs: got %b expected 1", spi_cs); end
        tests++; if (spi_sck !== 1'b0) begin fails++; $display("[TB] FAIL reset_sck: got %b expected 0", spi_sck); end
        tests++; if (spi_si !== 1'b0) begin fails++; $display("[TB] FAIL reset_si: got %b expected 0", spi_si); end
        tests++; if (tx_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 1", tx_ready); end
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        tests++; if (rx_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_rx_data: got %h expected 00", rx_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (cs1 !== 1'b1) begin fails++; $display("[TB] FAIL reset_cs_div1: got %b expected 1", cs1); end
    endtask

    task automatic test_single(input logic [7:0] d);
        loop_en = 1'b1;
        clear_mon();
        send_byte(d, 1'b1);
        wait_idle();
        tests++; if (rise_t.size() !== 8) begin fails++; $display("[TB] FAIL single_pulses(%h): got %0d expected 8", d, rise_t.size()); end
        tests++; if (bad_high !== 0 || bad_low !== 0) begin fails++; $display("[TB] FAIL single_phase(%h): bad high %0d low %0d, expected 0 0", d, bad_high, bad_low); end
        tests++; if (si_glitch !== 0) begin fails++; $display("[TB] FAIL single_si_stable(%h): got %0d changes expected 0", d, si_glitch); end
        tests++; if (qb(mosi_q, 0) !== d) begin fails++; $display("[TB] FAIL single_mosi: got %h expected %h", qb(mosi_q, 0), d); end
        tests++; if (rxv_t.size() !== 1) begin fails++; $display("[TB] FAIL single_rx_count(%h): got %0d expected 1", d, rxv_t.size()); end
        tests++; if (qb(rxd_q, 0) !== d) begin fails++; $display("[TB] FAIL single_rx_data: got %h expected %h", qb(rxd_q, 0), d); end
        tests++; if (qi(csf_t, 0) - qi(acc_t, 0) !== 1) begin fails++; $display("[TB] FAIL single_cs_fall(%h): got %0d expected 1", d, qi(csf_t, 0) - qi(acc_t, 0)); end
        tests++; if (qi(rise_t, 0) - qi(csf_t, 0) !== 2 * D) begin fails++; $display("[TB] FAIL single_first_rise(%h): got %0d expected %0d", d, qi(rise_t, 0) - qi(csf_t, 0), 2 * D); end
        tests++; if (qi(rxv_t, 0) - qi(csf_t, 0) !== 17 * D) begin fails++; $display("[TB] FAIL single_rx_time(%h): got %0d expected %0d", d, qi(rxv_t, 0) - qi(csf_t, 0), 17 * D); end
        tests++; if (qi(rxv_t, 0) !== qi(fall_t, 7)) begin fails++; $display("[TB] FAIL single_rx_at_fall(%h): got %0d expected %0d", d, qi(rxv_t, 0), qi(fall_t, 7)); end
        tests++; if (qi(csr_t, 0) - qi(fall_t, 7) !== D) begin fails++; $display("[TB] FAIL single_trail(%h): got %0d expected %0d", d, qi(csr_t, 0) - qi(fall_t, 7), D); end
        tests++; if (qi(busyf_t, 0) - qi(fall_t, 7) !== 2 * D) begin fails++; $display("[TB] FAIL single_gap(%h): got %0d expected %0d", d, qi(busyf_t, 0) - qi(fall_t, 7), 2 * D); end
    endtask

    task automatic test_burst(input int n, input logic fixed);
        logic [7:0] txb[4];
        logic [7:0] rxb[4];
        txb = '{8'h01, 8'h80, 8'hFF, 8'h00};
        rxb = '{8'h3C, 8'hC3, 8'h00, 8'h00};
        loop_en = 1'b0;
        clear_mon();
        for (int i = 0; i < n; i++) begin
            if (!fixed) begin
                txb[i] = 8'($urandom_range(0, 255));
                rxb[i] = 8'($urandom_range(0, 255));
            end
            miso_q.push_back(rxb[i]);
        end
        for (int i = 0; i < n; i++) send_byte(txb[i], i == n - 1);
        wait_idle();
        tests++; if (csf_t.size() !== 1 || csr_t.size() !== 1) begin fails++; $display("[TB] FAIL burst_cs_frame: falls %0d rises %0d expected 1 1", csf_t.size(), csr_t.size()); end
        tests++; if (rise_t.size() !== 8 * n) begin fails++; $display("[TB] FAIL burst_pulses: got %0d expected %0d", rise_t.size(), 8 * n); end
        tests++; if (rxv_t.size() !== n) begin fails++; $display("[TB] FAIL burst_rx_count: got %0d expected %0d", rxv_t.size(), n); end
        for (int i = 0; i < n; i++) begin
            tests++; if (qb(rxd_q, i) !== rxb[i]) begin fails++; $display("[TB] FAIL burst_rx_data[%0d]: got %h expected %h", i, qb(rxd_q, i), rxb[i]); end
            tests++; if (qb(mosi_q, i) !== txb[i]) begin fails++; $display("[TB] FAIL burst_mosi[%0d]: got %h expected %h", i, qb(mosi_q, i), txb[i]); end
            tests++; if (qi(rxv_t, i) - qi(acc_t, i) !== 1 + 17 * D) begin fails++; $display("[TB] FAIL burst_rx_time[%0d]: got %0d expected %0d", i, qi(rxv_t, i) - qi(acc_t, i), 1 + 17 * D); end
        end
        tests++; if (bad_high !== 0 || bad_low !== 0) begin fails++; $display("[TB] FAIL burst_phase: bad high %0d low %0d, expected 0 0", bad_high, bad_low); end
    endtask

    task automatic test_wait_gap();
        logic [7:0] t0, t1, r0, r1;
        int n, bad;
        t0 = 8'($urandom_range(0, 255)); t1 = 8'($urandom_range(0, 255));
        r0 = 8'($urandom_range(0, 255)); r1 = 8'($urandom_range(0, 255));
        loop_en = 1'b0;
        clear_mon();
        miso_q.push_back(r0);
        miso_q.push_back(r1);
        send_byte(t0, 1'b0);
        n = 0;
        while (rxv_t.size() < 1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (spi_cs !== 1'b0 || spi_sck !== 1'b0 || busy !== 1'b1 || tx_ready !== 1'b1) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("[TB] FAIL wait_hold: got %0d bad cycles expected 0", bad); end
        send_byte(t1, 1'b1);
        wait_idle();
        tests++; if (csf_t.size() !== 1) begin fails++; $display("[TB] FAIL wait_cs_frame: got %0d falls expected 1", csf_t.size()); end
        tests++; if (rise_t.size() !== 16) begin fails++; $display("[TB] FAIL wait_pulses: got %0d expected 16", rise_t.size()); end
        tests++; if (qb(rxd_q, 0) !== r0 || qb(rxd_q, 1) !== r1) begin fails++; $display("[TB] FAIL wait_rx_data: got %h %h expected %h %h", qb(rxd_q, 0), qb(rxd_q, 1), r0, r1); end
        tests++; if (qb(mosi_q, 1) !== t1) begin fails++; $display("[TB] FAIL wait_mosi: got %h expected %h", qb(mosi_q, 1), t1); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        int n, nacc;
        d = 8'($urandom_range(0, 255));
        loop_en = 1'b1;
        clear_mon();
        @(posedge clk); #1;
        tx_data = d; tx_last = 1'b1; tx_valid = 1'b1;
        n = 0; nacc = 0;
        while (nacc < 2 && n < 1000) begin
            @(negedge clk);
            if (tx_ready) nacc++;
            n++;
        end
        @(posedge clk); #1;
        tx_valid = 1'b0;
        wait_idle();
        tests++; if (acc_t.size() !== 2) begin fails++; $display("[TB] FAIL b2b_accepts: got %0d expected 2", acc_t.size()); end
        tests++; if (qi(acc_t, 1) - qi(acc_t, 0) !== 1 + 19 * D) begin fails++; $display("[TB] FAIL b2b_spacing: got %0d expected %0d", qi(acc_t, 1) - qi(acc_t, 0), 1 + 19 * D); end
        tests++; if (qi(acc_t, 1) !== qi(busyf_t, 0)) begin fails++; $display("[TB] FAIL b2b_idle_accept: got %0d expected %0d", qi(acc_t, 1), qi(busyf_t, 0)); end
        tests++; if (rxv_t.size() !== 2 || qb(rxd_q, 1) !== d) begin fails++; $display("[TB] FAIL b2b_rx: got %0d pulses last %h expected 2 pulses %h", rxv_t.size(), qb(rxd_q, 1), d); end
    endtask

    task automatic test_reset_mid();
        int n;
        loop_en = 1'b1;
        clear_mon();
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        n = 0;
        while (rise_t.size() < 4 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        tests++; if (spi_cs !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_cs_async: got %b expected 1", spi_cs); end
        tests++; if (spi_sck !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_sck_async: got %b expected 0", spi_sck); end
        #1;
        rst = 1'b0;
        rxv_t.delete();
        repeat (20 * D) @(negedge clk);
        tests++; if (rxv_t.size() !== 0) begin fails++; $display("[TB] FAIL rstmid_no_rx_valid: got %0d pulses expected 0", rxv_t.size()); end
        tests++; if (rx_data !== 8'h00 || busy !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_state: rx_data %h busy %b expected 00 0", rx_data, busy); end
        clear_mon();
        send_byte(8'h5A, 1'b1);
        wait_idle();
        tests++; if (rxv_t.size() !== 1 || qb(rxd_q, 0) !== 8'h5A) begin fails++; $display("[TB] FAIL rstmid_recover: got %0d pulses data %h expected 1 5a", rxv_t.size(), qb(rxd_q, 0)); end
    endtask

    task automatic test_div1();
        int n, csf, rxv, nrise, last_r, bad_per;
        logic pc, ps;
        logic [7:0] rxd, mo;
        csf = -1000; rxv = -1000; nrise = 0; last_r = -1; bad_per = 0;
        rxd = 8'hxx; mo = 8'h00;
        @(posedge clk); #1;
        tx_data1 = 8'hFF; tx_last1 = 1'b1; tx_valid1 = 1'b1;
        n = 0;
        @(negedge clk);
        while (!tx_ready1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        pc = cs1; ps = sck1;
        @(posedge clk); #1;
        tx_valid1 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (pc && !cs1) csf = cyc;
            if (!ps && sck1) begin
                if (last_r >= 0 && cyc - last_r != 2) bad_per++;
                last_r = cyc;
                nrise++;
                mo = {mo[6:0], si1};
            end
            if (rx_valid1) begin
                rxv = cyc;
                rxd = rx_data1;
            end
            pc = cs1; ps = sck1;
        end
        tests++; if (nrise !== 8) begin fails++; $display("[TB] FAIL div1_pulses: got %0d expected 8", nrise); end
        tests++; if (bad_per !== 0) begin fails++; $display("[TB] FAIL div1_period: got %0d bad periods expected 0", bad_per); end
        tests++; if (mo !== 8'hFF) begin fails++; $display("[TB] FAIL div1_mosi: got %h expected ff", mo); end
        tests++; if (rxd !== 8'h00) begin fails++; $display("[TB] FAIL div1_rx_data: got %h expected 00", rxd); end
        tests++; if (rxv - csf !== 17) begin fails++; $display("[TB] FAIL div1_rx_time: got %0d expected 17", rxv - csf); end
        tests++; if (busy1 !== 1'b0 || cs1 !== 1'b1) begin fails++; $display("[TB] FAIL div1_idle: busy %b cs %b expected 0 1", busy1, cs1); end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        tx_data = 8'h00; tx_valid = 1'b0; tx_last = 1'b0;
        tx_data1 = 8'h00; tx_valid1 = 1'b0; tx_last1 = 1'b0;
        loop_en = 1'b1;
        slave_so = 1'b0;
        clear_mon();
        test_reset();
        test_single(8'hA5);
        repeat (3) test_single(8'($urandom_range(0, 255)));
        test_burst(3, 1'b1);
        test_burst(int'($urandom_range(2, 4)), 1'b0);
        test_burst(int'($urandom_range(2, 4)), 1'b0);
        test_wait_gap();
        test_back_to_back();
        test_reset_mid();
        test_div1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
